tick_timer: RTL and testbench

// - Parametrised successor to the game's 2-second counter.
// - One clk_50M domain with an internal prescaler. Provides a programmable one-shot/periodic

---
 rtl/tick_timer.sv | 141 ++++++++++++++
 tb/tb_tick_timer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/tick_timer.sv
// Programmable one-shot/periodic tick timer with internal prescaler and a
// free-running seed counter, all in the single clk_50M domain.
module tick_timer #(
  parameter int WIDTH    = 12,
  parameter int TICK_DIV = 25000
) (
  input  logic             clk_50M,
  input  logic             i_Reset,
  input  logic             i_Clear,
  input  logic             i_Stop,
  input  logic             i_Start,
  input  logic             i_Mode,
  input  logic [WIDTH-1:0] i_Limit,
  input  logic             i_SeedEn,
  output logic [WIDTH-1:0] o_Count,
  output logic [WIDTH-1:0] o_Seed,
  output logic             o_Busy,
  output logic             o_Done,
  output logic             o_Expired
);

  localparam int            PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_EXPIRED
  } state_e;

  state_e           state_q,   state_d;
  logic [PW-1:0]    presc_q,   presc_d;
  logic [WIDTH-1:0] count_q,   count_d;
  logic [WIDTH-1:0] limit_q,   limit_d;
  logic             mode_q,    mode_d;
  logic             done_q,    done_d;
  logic             expired_q, expired_d;
  logic [WIDTH-1:0] seed_q,    seed_d;

  logic             tick;
  logic [WIDTH-1:0] last_count;

  // Count value on which the next tick is terminal; only meaningful when the
  // latched limit is non-zero.
  assign last_count = limit_q - WIDTH'(1);

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    count_d   = count_q;
    limit_d   = limit_q;
    mode_d    = mode_q;
    done_d    = 1'b0;
    expired_d = expired_q;
    tick      = 1'b0;

    // The seed counter ignores every timer control; only reset touches it.
    seed_d = seed_q + WIDTH'(i_SeedEn);

    if (i_Clear) begin
      state_d   = ST_IDLE;
      presc_d   = '0;
      count_d   = '0;
      expired_d = 1'b0;
    end else if (i_Stop) begin
      if (state_q == ST_RUN) begin
        state_d = ST_IDLE;
      end
    end else if (i_Start) begin
      state_d   = ST_RUN;
      limit_d   = i_Limit;
      mode_d    = i_Mode;
      presc_d   = '0;
      count_d   = '0;
      expired_d = 1'b0;
    end else if (state_q == ST_RUN) begin
      if (limit_q == '0) begin
        // A zero limit expires on the first edge in either mode.
        state_d   = ST_EXPIRED;
        count_d   = '0;
        done_d    = 1'b1;
        expired_d = 1'b1;
      end else begin
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          tick    = 1'b1;
        end else begin
          presc_d = presc_q + PW'(1);
        end

        if (tick) begin
          if (count_q == last_count) begin
            done_d = 1'b1;
            if (mode_q) begin
              count_d = '0;
            end else begin
              count_d   = limit_q;
              state_d   = ST_EXPIRED;
              expired_d = 1'b1;
            end
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk_50M) begin
    if (i_Reset) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      count_q   <= '0;
      limit_q   <= '0;
      mode_q    <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
      seed_q    <= '0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      count_q   <= count_d;
      limit_q   <= limit_d;
      mode_q    <= mode_d;
      done_q    <= done_d;
      expired_q <= expired_d;
      seed_q    <= seed_d;
    end
  end

  assign o_Count   = count_q;
  assign o_Seed    = seed_q;
  assign o_Busy    = (state_q == ST_RUN);
  assign o_Done    = done_q;
  assign o_Expired = expired_q;

endmodule

// File: tb/tb_tick_timer.sv
// Directed plus randomized bench for tick_timer; expected outputs come from an
// arithmetic model based on edges elapsed since the start edge.
module tb_tick_timer;

  localparam int WIDTH    = 4;
  localparam int TICK_DIV = 4;
  localparam int MASK     = (1 << WIDTH) - 1;

  logic             clk_50M = 1'b0;
  logic             i_Reset, i_Clear, i_Stop, i_Start, i_Mode, i_SeedEn;
  logic [WIDTH-1:0] i_Limit;
  logic [WIDTH-1:0] o_Count, o_Seed;
  logic             o_Busy, o_Done, o_Expired;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: edges elapsed since the start edge drive everything.
  bit m_running, m_expired, m_periodic, m_done;
  int m_n, m_limit, m_count, m_seed;

  tick_timer #(.WIDTH(WIDTH), .TICK_DIV(TICK_DIV)) dut (
    .clk_50M  (clk_50M),
    .i_Reset  (i_Reset),
    .i_Clear  (i_Clear),
    .i_Stop   (i_Stop),
    .i_Start  (i_Start),
    .i_Mode   (i_Mode),
    .i_Limit  (i_Limit),
    .i_SeedEn (i_SeedEn),
    .o_Count  (o_Count),
    .o_Seed   (o_Seed),
    .o_Busy   (o_Busy),
    .o_Done   (o_Done),
    .o_Expired(o_Expired)
  );

  always #5 clk_50M = ~clk_50M;

  task automatic check(input string tag, input string field,
                       input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s.%s: observed %0h expected %0h", tag, field, obs, exp);
  endtask

  task automatic set_in(input bit rst, input bit clr, input bit stp, input bit strt,
                        input bit mode, input int limit, input bit seed_en);
    i_Reset  = rst;
    i_Clear  = clr;
    i_Stop   = stp;
    i_Start  = strt;
    i_Mode   = mode;
    i_Limit  = WIDTH'(limit);
    i_SeedEn = seed_en;
  endtask

  // Advance the model by one edge using the inputs the DUT sees on that edge.
  task automatic model_edge();
    int ticks;
    m_done = 1'b0;
    if (i_Reset) begin
      m_running = 1'b0; m_expired = 1'b0; m_periodic = 1'b0;
      m_n = 0; m_limit = 0; m_count = 0; m_seed = 0;
    end else begin
      m_seed = (m_seed + int'(i_SeedEn)) & MASK;
      if (i_Clear) begin
        m_running = 1'b0; m_expired = 1'b0; m_count = 0;
      end else if (i_Stop) begin
        m_running = 1'b0;
      end else if (i_Start) begin
        m_limit    = int'(i_Limit);
        m_periodic = i_Mode && (m_limit != 0);
        m_running  = 1'b1; m_expired = 1'b0; m_count = 0; m_n = 0;
      end else if (m_running) begin
        m_n++;
        ticks = m_n / TICK_DIV;
        if (m_limit == 0) begin
          m_done = 1'b1; m_running = 1'b0; m_expired = 1'b1; m_count = 0;
        end else if (m_periodic) begin
          m_count = ticks % m_limit;
          m_done  = (m_n % TICK_DIV == 0) && (ticks % m_limit == 0);
        end else begin
          m_count = (ticks < m_limit) ? ticks : m_limit;
          if (ticks == m_limit && m_n % TICK_DIV == 0) begin
            m_done = 1'b1; m_running = 1'b0; m_expired = 1'b1;
          end
        end
      end
    end
  endtask

  // One clock edge: update the model, then compare every output 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk_50M);
    model_edge();
    #1;
    check(tag, "count",   o_Count,   WIDTH'(m_count));
    check(tag, "seed",    o_Seed,    WIDTH'(m_seed));
    check(tag, "busy",    WIDTH'(o_Busy),    WIDTH'(m_running));
    check(tag, "done",    WIDTH'(o_Done),    WIDTH'(m_done));
    check(tag, "expired", WIDTH'(o_Expired), WIDTH'(m_expired));
  endtask

  task automatic idle_steps(input int n, input string tag);
    set_in(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    // Reset with every input high.
    set_in(1, 1, 1, 1, 1, 15, 1);
    for (int i = 0; i < 3; i++) step("reset");
    check("reset", "count_zero", o_Count, '0);
    idle_steps(3, "seed_count");

    // One-shot, limit 3.
    set_in(0, 0, 0, 1, 0, 3, 1);
    step("os_start");
    idle_steps(13, "oneshot");
    check("oneshot", "count_hold", o_Count, WIDTH'(3));
    check("oneshot", "expired_hold", WIDTH'(o_Expired), WIDTH'(1));

    // Periodic, limit 2.
    set_in(0, 0, 0, 1, 1, 2, 1);
    step("per_start");
    idle_steps(25, "periodic");

    // One-shot limit 5, stop at E6, clear at E9, fresh run.
    set_in(0, 0, 0, 1, 0, 5, 1);
    step("stop_start");
    idle_steps(5, "stop_run");
    set_in(0, 0, 1, 0, 0, 5, 1);
    step("stop_edge");
    idle_steps(2, "stopped");
    check("stopped", "count_frozen", o_Count, WIDTH'(1));
    set_in(0, 1, 0, 0, 0, 5, 1);
    step("clear_edge");
    idle_steps(1, "cleared");
    set_in(0, 0, 0, 1, 0, 2, 1);
    step("fresh_start");
    idle_steps(9, "fresh");

    // Same-edge priority cases and zero limit.
    set_in(0, 0, 1, 1, 0, 3, 1);
    step("start_stop");
    idle_steps(2, "start_stop_after");
    set_in(0, 1, 0, 1, 0, 3, 1);
    step("clear_start");
    idle_steps(2, "clear_start_after");
    set_in(0, 0, 0, 1, 1, 0, 1);
    step("limit0_start");
    idle_steps(3, "limit0");
    check("limit0", "expired_set", WIDTH'(o_Expired), WIDTH'(1));

    // Seed wrap after 17 enabled edges from zero.
    set_in(1, 0, 0, 0, 0, 0, 0);
    step("seed_reset");
    for (int i = 0; i < 17; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 1);
      step("seed_wrap");
    end
    check("seed_wrap", "seed_one", o_Seed, WIDTH'(1));

    // Reset in the middle of a run.
    set_in(0, 0, 0, 1, 0, 3, 1);
    step("rst_mid_start");
    idle_steps(5, "rst_mid_run");
    set_in(1, 0, 0, 0, 0, 3, 1);
    step("rst_mid_edge");
    idle_steps(16, "rst_mid_after");

    // Randomized traffic; limit and mode wiggle every cycle.
    for (int i = 0; i < 1500; i++) begin
      set_in(($urandom_range(255) == 0), ($urandom_range(63) == 0),
             ($urandom_range(31) == 0), ($urandom_range(15) == 0),
             1'($urandom_range(1)), int'($urandom_range(MASK)),
             1'($urandom_range(1)));
      step("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
